// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read IM, and feeds IF/ID
// through a one-entry skid buffer. Define FETCH_PERF_CNT_EN to add fetch/stall counters.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   im_addr,
  input  logic [0:INSTR_W-1]  im_dout,
  input  logic                stall,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [0:INSTR_W-1]  if_instr,
  output logic                if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [0:0]         state;
  logic [ADDR_W-1:0]  pc_q;
  logic               rsp_vld_q;
  logic [ADDR_W-1:0]  rsp_pc_q;
  logic               skid_vld_q;
  logic [ADDR_W-1:0]  skid_pc_q;
  logic [0:INSTR_W-1] skid_instr_q;

  assign im_addr = pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      pc_q         <= RESET_PC;
      rsp_vld_q    <= 1'b0;
      rsp_pc_q     <= '0;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      if_valid     <= 1'b0;
      if_pc        <= '0;
      if_instr     <= '0;
    end else if (redirect) begin
      pc_q       <= {redirect_pc[ADDR_W-1:2], 2'b00};
      rsp_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      if_valid   <= 1'b0;
      state      <= RUN;
    end else if (state == RUN) begin
      if (!stall) begin
        if_pc     <= rsp_pc_q;
        if_instr  <= im_dout;
        if_valid  <= rsp_vld_q;
        rsp_pc_q  <= pc_q;
        rsp_vld_q <= 1'b1;
        pc_q      <= pc_q + PC_STEP;
      end else if (rsp_vld_q) begin
        // Park the returning word; pc_q is re-presented so im_dout keeps word(pc_q).
        skid_pc_q    <= rsp_pc_q;
        skid_instr_q <= im_dout;
        skid_vld_q   <= 1'b1;
        rsp_pc_q     <= pc_q;
        state        <= HOLD;
      end else begin
        // The response slot now owns pc_q's word, so fetch moves on to the next one.
        rsp_pc_q  <= pc_q;
        rsp_vld_q <= 1'b1;
        pc_q      <= pc_q + PC_STEP;
      end
    end else if (!stall) begin
      // Drain the skid; rsp still names pc_q, whose word arrives from the last read,
      // so the address already moves to the following word.
      if_pc      <= skid_pc_q;
      if_instr   <= skid_instr_q;
      if_valid   <= skid_vld_q;
      skid_vld_q <= 1'b0;
      pc_q       <= pc_q + PC_STEP;
      state      <= RUN;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic load_valid;

  always_comb begin
    load_valid = 1'b0;
    if (!redirect && !stall)
      load_valid = (state == RUN) ? rsp_vld_q : skid_vld_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (load_valid && (perf_fetch_cnt != '1))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && if_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random stall/redirect
// traffic, checked against an in-order fetch-stream model and a behavioural IM.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic [31:0] im_addr;
  logic [0:31] im_dout;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [0:31] if_instr;
  logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  if_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .im_addr(im_addr),
    .im_dout(im_dout),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .if_valid(if_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  // Synchronous-read instruction memory
  always @(posedge clk) im_dout <= mem_word(im_addr);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the delivered stream is next_pc, next_pc+4, ...; the first word
  // after a flush needs one non-flush edge before any unstalled edge can deliver it.
  logic        exp_valid;
  logic [31:0] exp_pc;
  logic [31:0] next_pc;
  int          since;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_pc    = '0;
    next_pc   = RESET_PC;
    since     = 0;
    m_fetch   = '0;
    m_stall   = '0;
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (s && exp_valid) m_stall = m_stall + 32'd1;
    @(posedge clk);
    #1;
    if (r) begin
      exp_valid = 1'b0;
      next_pc   = {rpc[31:2], 2'b00};
      since     = 0;
      check("redirect_im_addr", 64'(im_addr), 64'(next_pc));
    end else begin
      if (!s) begin
        if (since >= 1) begin
          exp_valid = 1'b1;
          exp_pc    = next_pc;
          next_pc   = next_pc + 32'd4;
          m_fetch   = m_fetch + 32'd1;
        end else begin
          exp_valid = 1'b0;
        end
      end
      since++;
    end
    check("if_valid", 64'(if_valid), 64'(exp_valid));
    if (exp_valid) begin
      check("if_pc", 64'(if_pc), 64'(exp_pc));
      check("if_instr", 64'(if_instr), 64'(mem_word(exp_pc)));
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(m_fetch));
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    @(posedge clk);
    #1;
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    rst = 1'b0;
    check("rst_im_addr", 64'(im_addr), 64'(RESET_PC));
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Streaming from reset, then a 3-cycle stall while 0x3004 is presented
    repeat (3) step(1'b0, 1'b0, '0);
    check("stall_start_pc", 64'(if_pc), 64'h3004);
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);

    // Redirect to a misaligned target mid-stream
    step(1'b0, 1'b1, 32'h0000_3103);
    repeat (3) step(1'b0, 1'b0, '0);

    // Redirect together with stall while in HOLD
    repeat (2) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0000_4000);
    repeat (2) step(1'b1, 1'b0, '0);
    repeat (3) step(1'b0, 1'b0, '0);

    // Address wrap at the top of the space
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, '0);
    check("wrap_im_addr_1", 64'(im_addr), 64'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    check("wrap_im_addr_2", 64'(im_addr), 64'h0000_0000);
    repeat (3) step(1'b0, 1'b0, '0);

    // Asynchronous reset between edges while stalled
    repeat (3) step(1'b1, 1'b0, '0);
    #3 rst = 1'b1;
    #1;
    check("async_rst_if_valid", 64'(if_valid), 64'd0);
    check("async_rst_im_addr", 64'(im_addr), 64'(RESET_PC));
`ifdef FETCH_PERF_CNT_EN
    check("async_rst_fetch_cnt", 64'(perf_fetch_cnt), 64'd0);
    check("async_rst_stall_cnt", 64'(perf_stall_cnt), 64'd0);
`endif
    #1 rst = 1'b0;
    model_reset();
    stall = 1'b0;
    repeat (4) step(1'b0, 1'b0, '0);

    // Random stall / redirect traffic
    for (int i = 0; i < 1500; i++) begin
      logic        s;
      logic        r;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 9) < 3);
      r   = ($urandom_range(0, 29) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom);
      step(s, r, rpc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
